bcd_gate_counter: RTL
=====================

# bcd_gate_counter

Eight-digit synchronous BCD event counter with a display holding register, sitting directly upstream of the seven-segment decoder in the frequency meter. It counts single-cycle edge-enable pulses from the input edge detector during a gate window. On the gate-end strobe it transfers the count into a holding register. It then presents one latched digit at a time, with leading-zero blanking, to the display multiplexer.

## Interface
- LZB, 1: leading-zero blanking enable. 1 = blank leading zeros, 0 = show all digits.
- BLANK_CODE, 4'hF: code driven for a blanked digit. It must be an invalid BCD value so the decoder shows all segments off.
- fpga_clk  in  1  system clock, 10 or 50 MHz; all state changes on its rising edge.
- nreset  in  1  reset, asynchronous, active-low.
- clk_enable  in  1  count-enable pulse; one cycle high per input rising edge.
- latchit  in  1  gate-end strobe; one cycle high; copies the live count to the holding register.
- reset_ctr  in  1  synchronous clear of the live count and live overflow; one cycle high.
- digit_select  in  3  digit index, 0 = least significant, 7 = most significant.
- digit_muxed  out  4  BCD value of the selected latched digit, or BLANK_CODE.
- carry_out  out  1  latched overflow flag; 1 = the last gate exceeded 99,999,999 events.

## Operation
- Live counter: eight 4-bit BCD digits, L0 (LS) to L7 (MS).
- Increment condition: clk_enable=1 and reset_ctr=0 and live overflow=0.
- Increment rule: digit Li increments when every lower digit equals 9. A digit at 9 that increments goes to 0. All digits update in the same cycle, so there is no ripple across cycles.
- Saturation: at 99,999,999 with an increment condition, the counter holds 99,999,999 and sets the live overflow flag (sticky). While the flag is set, further clk_enable pulses are ignored.
- reset_ctr=1: live digits go to 0 and live overflow goes to 0. This takes priority over clk_enable in the same cycle, and that event is dropped.
- latchit=1: holding digits H0..H7 take the current registered L0..L7, and the latched overflow takes the live overflow. The capture uses the pre-update value, so an increment in the same cycle is not captured. latchit does not clear the live count.
- latchit and reset_ctr in the same cycle: the latch captures the pre-clear value, then the clear applies.
- Digit output: digit_muxed = H[digit_select], subject to blanking.
- Blanking: with LZB=1, digit d is blanked when d>0 and Hd..H7 are all 0. Digit 0 is never blanked, so a zero count shows a single "0".
- Overflow display: while carry_out=1, digit values are the saturated 9s, so no blanking occurs.
- Digit selects 6 and 7 are fully supported even if the board muxer only scans 0-5.
- Invalid BCD can never reach the live or holding registers.

## Timing
- Reset (nreset=0, asynchronous): all live digits, holding digits and both overflow flags are 0. Therefore carry_out=0. digit_muxed is 0 for digit_select=0 and BLANK_CODE for selects 1-7 (with LZB=1).
- Live count reflects clk_enable one cycle after the pulse edge.
- Holding register and carry_out update on the edge where latchit=1. They are visible in the following cycle.
- digit_muxed is combinational from the holding register and digit_select. It responds within the same cycle; the decoder registers it.
- Throughput: one count per cycle is accepted (clk_enable high on consecutive cycles counts each cycle).
- Reset deasserted mid-gate: the count restarts from 0; the holding register shows 0 until the next latchit.

## Test plan
- Reset then no stimulus -> digit_muxed = 0 at select 0, 4'hF at selects 1-7; carry_out = 0.
- 1234 clk_enable pulses, then latchit -> selects 0..3 give 4,3,2,1; selects 4..7 give 4'hF. A second latchit with no further pulses gives the same values.
- Preload via 99,999,998 pulses, then 5 more, then latchit -> all digits 9, carry_out=1. Then reset_ctr, 7 pulses, latchit -> carry_out=0, digit 0 = 7.
- clk_enable and reset_ctr asserted together, then latchit -> digit 0 = 0, and no count is carried over.
- latchit, reset_ctr and clk_enable in the same cycle on live count 500 -> latched value 500; live count 0 afterwards.
- 10 pulses with LZB=0 -> selects 0..7 give 0,1,0,0,0,0,0,0, with no BLANK_CODE.

Source files
------------

// File: rtl/bcd_gate_counter.sv
// Eight-digit BCD gate counter with holding register and leading-zero-blanked digit mux.
// DIGITS narrows the counted width (upper digits stay 0); the frequency meter uses 8.
module bcd_gate_counter #(
    parameter bit         LZB        = 1'b1,
    parameter logic [3:0] BLANK_CODE = 4'hF,
    parameter int         DIGITS     = 8
) (
    input  logic       fpga_clk,
    input  logic       nreset,
    input  logic       clk_enable,
    input  logic       latchit,
    input  logic       reset_ctr,
    input  logic [2:0] digit_select,
    output logic [3:0] digit_muxed,
    output logic       carry_out
);

    logic [3:0] live_q [8];
    logic [3:0] live_d [8];
    logic [3:0] hold_q [8];
    logic       live_ovf_q;
    logic       live_ovf_d;
    logic       hold_ovf_q;
    logic [8:0] lower_nine;
    logic [7:0] upper_zero;
    logic       inc;
    logic       sat;
    logic       blank;

    // lower_nine[i]: every digit below i is 9, so digit i takes the carry this cycle
    always_comb begin
        logic run;
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            lower_nine[i] = run;
            run           = run & (live_q[i] == 4'd9);
        end
        lower_nine[8] = run;

        inc = clk_enable && !reset_ctr && !live_ovf_q;
        sat = lower_nine[DIGITS];

        for (int i = 0; i < 8; i++) begin
            live_d[i] = live_q[i];
            if (i >= DIGITS || reset_ctr) begin
                live_d[i] = 4'd0;
            end else if (inc && !sat && lower_nine[i]) begin
                live_d[i] = (live_q[i] >= 4'd9) ? 4'd0 : live_q[i] + 4'd1;
            end
        end

        live_ovf_d = live_ovf_q;
        if (reset_ctr) begin
            live_ovf_d = 1'b0;
        end else if (inc && sat) begin
            live_ovf_d = 1'b1;
        end
    end

    always_ff @(posedge fpga_clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < 8; i++) begin
                live_q[i] <= 4'd0;
                hold_q[i] <= 4'd0;
            end
            live_ovf_q <= 1'b0;
            hold_ovf_q <= 1'b0;
        end else begin
            // Holding register samples the pre-update live value
            if (latchit) begin
                for (int i = 0; i < 8; i++) begin
                    hold_q[i] <= live_q[i];
                end
                hold_ovf_q <= live_ovf_q;
            end
            for (int i = 0; i < 8; i++) begin
                live_q[i] <= live_d[i];
            end
            live_ovf_q <= live_ovf_d;
        end
    end

    // upper_zero[d]: held digits d..7 are all zero
    always_comb begin
        logic run;
        run = 1'b1;
        for (int d = 7; d >= 0; d--) begin
            run           = run & (hold_q[d] == 4'd0);
            upper_zero[d] = run;
        end
        blank       = LZB && (digit_select != 3'd0) && upper_zero[digit_select];
        digit_muxed = blank ? BLANK_CODE : hold_q[digit_select];
    end

    assign carry_out = hold_ovf_q;

endmodule
